// File: rtl/mult_div_pkg.sv
// Shared types and sizing constants for the mult_div unit.
package mult_div_pkg;

    localparam int unsigned OP_W   = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned ITERS  = 32;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add32.sv
// 32-bit ripple-carry adder used as the multiplier datapath adder.
module add32
    import mult_div_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            cin,
    output logic [OP_W-1:0] sum,
    output logic            cout
);

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < int'(OP_W); i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/mult32_seq.sv
// Sequential unsigned 32x32->64 shift-add multiplier, one add/shift per clock.
module mult32_seq
    import mult_div_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     a_q, a_d;
    logic [PROD_W-1:0]   p_q, p_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [OP_W-1:0]     add_sum;
    logic                add_cout;
    logic [PROD_W-1:0]   p_step;
    logic                zero_hit;

    add32 u_add32 (
        .a    (p_q[PROD_W-1:OP_W]),
        .b    (a_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // One shift-add step: add the multiplicand into the high word when the LSB is set.
    always_comb begin
        if (p_q[0]) begin
            p_step = {add_cout, add_sum, p_q[OP_W-1:1]};
        end else begin
            p_step = {1'b0, p_q[PROD_W-1:OP_W], p_q[OP_W-1:1]};
        end
    end

    // Zero skip applies only from IDLE so that done never stays high for two cycles.
    assign zero_hit = ZERO_SKIP && (state_q == IDLE) &&
                      ((a == OP_W'(0)) || (b == OP_W'(0)));

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        p_d       = p_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d   = a;
                    cnt_d = CNT_W'(0);
                    if (zero_hit) begin
                        p_d       = PROD_W'(0);
                        product_d = PROD_W'(0);
                        state_d   = DONE;
                    end else begin
                        p_d     = {OP_W'(0), b};
                        state_d = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                p_d   = p_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    product_d = p_step;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            p_q       <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            p_q       <= p_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_mult32_seq.sv
// Bench for mult32_seq: directed cases plus random traffic against a cycle-level model.
module tb_mult32_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start;
    logic [31:0] a, b;
    logic        busy0, done0, busy1, done1;
    logic [63:0] product0, product1;

    int checks = 0;
    int errors = 0;

    mult32_seq #(.ZERO_SKIP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy0), .done(done0), .product(product0)
    );

    mult32_seq #(.ZERO_SKIP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy1), .done(done1), .product(product1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Model: mode 0 idle, 1 running (rem cycles left), 2 done; result from plain multiply.
    int          mode [2];
    int          rem  [2];
    logic [63:0] pend [2];
    logic [63:0] mprod[2];
    bit          mvalid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mode[i]  <= 0;
                rem[i]   <= 0;
                mprod[i] <= 64'd0;
            end else if (mode[i] == 1) begin
                rem[i] <= rem[i] - 1;
                if (rem[i] == 1) begin
                    mode[i]  <= 2;
                    mprod[i] <= pend[i];
                end
            end else if (start) begin
                if (i == 1 && mode[i] == 0 && (a == 32'd0 || b == 32'd0)) begin
                    mode[i]  <= 2;
                    mprod[i] <= 64'd0;
                end else begin
                    mode[i] <= 1;
                    rem[i]  <= 32;
                    pend[i] <= 64'(a) * 64'(b);
                end
            end else if (mode[i] == 2) begin
                mode[i] <= 0;
            end
        end
        mvalid <= 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("m_busy0", 64'(busy0), 64'(mode[0] == 1));
            chk("m_done0", 64'(done0), 64'(mode[0] == 2));
            chk("m_prod0", product0, mprod[0]);
            chk("m_busy1", 64'(busy1), 64'(mode[1] == 1));
            chk("m_done1", 64'(done1), 64'(mode[1] == 2));
            chk("m_prod1", product1, mprod[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          lat0, lat1, bc0, bc1;
    logic [63:0] p0, p1;

    // Issue one operation after an idle cycle; optionally re-assert start (7x7) at cycle poke.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input int poke);
        int n;
        start = 1'b0;
        step();
        a = av; b = bv; start = 1'b1;
        step();
        start = 1'b0; a = $urandom; b = $urandom;
        n = 1; lat0 = 0; lat1 = 0; bc0 = 0; bc1 = 0; p0 = '0; p1 = '0;
        forever begin
            if (busy0) bc0++;
            if (busy1) bc1++;
            if (done0 && lat0 == 0) begin lat0 = n; p0 = product0; end
            if (done1 && lat1 == 0) begin lat1 = n; p1 = product1; end
            if ((lat0 != 0 && lat1 != 0) || n >= 40) break;
            if (n == poke) begin start = 1'b1; a = 32'd7; b = 32'd7; end
            else start = 1'b0;
            step();
            n++;
        end
        start = 1'b0;
    endtask

    initial begin
        int n;
        int hold_bad;
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) step();
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_prod0", product0, 64'd0);
        chk("rst_prod1", product1, 64'd0);
        reset = 1'b0;

        run_op(32'd3, 32'd5, 0);
        chk("3x5_lat", 64'(lat0), 64'd33);
        chk("3x5_busy_cycles", 64'(bc0), 64'd32);
        chk("3x5_prod", p0, 64'h0000_0000_0000_000F);
        chk("3x5_zs_lat", 64'(lat1), 64'd33);
        chk("3x5_model", mprod[0], 64'd15);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("ffxff_prod", p0, 64'hFFFF_FFFE_0000_0001);
        chk("ffxff_zs_prod", p1, 64'hFFFF_FFFE_0000_0001);
        chk("ffxff_model", mprod[0], 64'hFFFF_FFFE_0000_0001);

        run_op(32'd3, 32'd5, 10);
        chk("ignore_start_lat", 64'(lat0), 64'd33);
        chk("ignore_start_prod", p0, 64'd15);

        // Reset in the middle of RUN discards the partial result.
        step();
        a = 32'd3; b = 32'd5; start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_busy", 64'(busy0), 64'd0);
        chk("midrst_done", 64'(done0), 64'd0);
        chk("midrst_prod", product0, 64'd0);
        chk("midrst_busy1", 64'(busy1), 64'd0);
        run_op(32'd2, 32'd2, 0);
        chk("2x2_lat", 64'(lat0), 64'd33);
        chk("2x2_prod", p0, 64'd4);

        run_op(32'd0, 32'h1234, 0);
        chk("zs_lat", 64'(lat1), 64'd1);
        chk("zs_prod", p1, 64'd0);
        chk("zs_busy_cycles", 64'(bc1), 64'd0);
        chk("nozs_lat", 64'(lat0), 64'd33);
        chk("nozs_prod", p0, 64'd0);

        // Back-to-back accept during DONE; old product must hold through the new RUN.
        step();
        a = 32'd3; b = 32'd5; start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!done0 && n < 40) begin
            step();
            n++;
        end
        chk("b2b_first_lat", 64'(n), 64'd33);
        chk("b2b_first_prod", product0, 64'd15);
        a = 32'd6; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        hold_bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (!busy0 || product0 !== 64'd15) hold_bad++;
            step();
        end
        chk("b2b_hold", 64'(hold_bad), 64'd0);
        chk("b2b_done", 64'(done0), 64'd1);
        chk("b2b_prod", product0, 64'd42);

        // Random traffic: sparse starts, zero operands, occasional resets.
        repeat (1500) begin
            reset = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 7) == 0);
            a = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            step();
        end
        reset = 1'b0; start = 1'b0;
        repeat (40) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
